// File: rtl/perceptron_pkg.sv
// Shared types, state codes and width helpers for the perceptron classifier
// and its neighbours (feature extractor, output decoder).
package perceptron_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAC   = 3'd1;
  localparam logic [2:0] ST_CMP   = 3'd2;
  localparam logic [2:0] ST_LEARN = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  function automatic int acc_width(input int feat_w, input int weight_w, input int n_feat);
    return feat_w + weight_w + 1 + $clog2(n_feat + 1);
  endfunction

  function automatic int cls_width(input int n_class);
    return $clog2(n_class);
  endfunction

  function automatic int sel_width(input int n_feat);
    return $clog2(n_feat + 1);
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement value.
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/perceptron_mac_if.sv
// Sample/result handshakes and weight-write port of the perceptron classifier.
// master = upstream/downstream logic driving samples, slave = the classifier.
interface perceptron_mac_if
  import perceptron_pkg::*;
#(
  parameter int N_FEAT   = 2,
  parameter int FEAT_W   = 4,
  parameter int N_CLASS  = 10,
  parameter int WEIGHT_W = 4,
  parameter int ACC_W    = acc_width(FEAT_W, WEIGHT_W, N_FEAT)
);
  logic                              in_valid;
  logic                              in_ready;
  logic [N_FEAT*FEAT_W-1:0]          in_feat;
  logic                              in_learn;
  logic [cls_width(N_CLASS)-1:0]     in_label;

  logic                              w_we;
  logic [cls_width(N_CLASS)-1:0]     w_class;
  logic [sel_width(N_FEAT)-1:0]      w_sel;
  logic signed [WEIGHT_W-1:0]        w_data;

  logic                              out_valid;
  logic                              out_ready;
  logic [cls_width(N_CLASS)-1:0]     out_class;
  logic signed [ACC_W-1:0]           out_score;
  logic                              out_err;

  modport master (
    output in_valid, in_feat, in_learn, in_label,
    output w_we, w_class, w_sel, w_data,
    output out_ready,
    input  in_ready, out_valid, out_class, out_score, out_err
  );

  modport slave (
    input  in_valid, in_feat, in_learn, in_label,
    input  w_we, w_class, w_sel, w_data,
    input  out_ready,
    output in_ready, out_valid, out_class, out_score, out_err
  );
endinterface

// File: rtl/perceptron_sat_upd.sv
// Combinational weight update w +/- x, clamped to the signed weight range.
// Zero latency, no handshake.
module perceptron_sat_upd
  import perceptron_pkg::*;
#(
  parameter int WEIGHT_W = 4,
  parameter int FEAT_W   = 4
) (
  input  logic signed [WEIGHT_W-1:0] w_in,
  input  logic        [FEAT_W-1:0]   x,
  input  logic                       sub,
  output logic signed [WEIGHT_W-1:0] w_out
);
  always_comb begin
    w_out = WEIGHT_W'(sat_add(int'(w_in), sub ? -int'(x) : int'(x), WEIGHT_W));
  end
endmodule

// File: rtl/perceptron_mac.sv
// Multi-class perceptron, one shared MAC, trainable flop weights, arg-max out.
// Latency N_CLASS*N_FEAT+1 (+N_FEAT on update); one sample in flight, result held until out_ready.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int N_FEAT   = 2,
  parameter int FEAT_W   = 4,
  parameter int N_CLASS  = 10,
  parameter int WEIGHT_W = 4,
  parameter int ACC_W    = acc_width(FEAT_W, WEIGHT_W, N_FEAT)
) (
  input logic             clk,
  input logic             rst,
  perceptron_mac_if.slave bus
);
  localparam int CW = cls_width(N_CLASS);
  localparam int JW = sel_width(N_FEAT);

  state_t                     state_q, state_d;
  logic [CW-1:0]              cls_q, cls_d;
  logic [CW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              label_q, label_d;
  logic [CW-1:0]              out_class_q, out_class_d;
  logic [JW-1:0]              j_q, j_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    max_q, max_d;
  logic signed [ACC_W-1:0]    out_score_q, out_score_d;
  logic                       learn_q, learn_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_err_q, out_err_d;
  logic [FEAT_W-1:0]          feat_q [N_FEAT];
  logic [FEAT_W-1:0]          feat_d [N_FEAT];
  // Index N_FEAT of each row is the bias.
  logic signed [WEIGHT_W-1:0] w_q [N_CLASS][N_FEAT+1];
  logic signed [WEIGHT_W-1:0] w_d [N_CLASS][N_FEAT+1];

  logic signed [WEIGHT_W-1:0] w_cur;
  logic signed [WEIGHT_W-1:0] lbl_w_new;
  logic signed [WEIGHT_W-1:0] prd_w_new;
  logic        [FEAT_W-1:0]   x_cur;
  logic signed [ACC_W-1:0]    prod;
  logic signed [ACC_W-1:0]    total;
  logic                       do_update;

  assign w_cur = w_q[cls_q][j_q];
  assign x_cur = feat_q[j_q];
  assign prod  = ACC_W'(w_cur) * $signed(ACC_W'(x_cur));
  assign total = ((j_q == '0) ? ACC_W'(w_q[cls_q][N_FEAT]) : acc_q) + prod;

  // An out-of-range label means "unlabelled": never train on it.
  assign do_update = learn_q
                     && ({1'b0, label_q} < (CW+1)'(N_CLASS))
                     && (label_q != idx_q);

  perceptron_sat_upd #(.WEIGHT_W(WEIGHT_W), .FEAT_W(FEAT_W)) u_upd_lbl (
    .w_in  (w_q[label_q][j_q]),
    .x     (x_cur),
    .sub   (1'b0),
    .w_out (lbl_w_new)
  );

  perceptron_sat_upd #(.WEIGHT_W(WEIGHT_W), .FEAT_W(FEAT_W)) u_upd_prd (
    .w_in  (w_q[idx_q][j_q]),
    .x     (x_cur),
    .sub   (1'b1),
    .w_out (prd_w_new)
  );

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    idx_d       = idx_q;
    label_d     = label_q;
    out_class_d = out_class_q;
    j_d         = j_q;
    acc_d       = acc_q;
    max_d       = max_q;
    out_score_d = out_score_q;
    learn_d     = learn_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    feat_d      = feat_q;
    w_d         = w_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.w_we) w_d[bus.w_class][bus.w_sel] = bus.w_data;
        if (bus.in_valid) begin
          for (int j = 0; j < N_FEAT; j++) feat_d[j] = bus.in_feat[j*FEAT_W +: FEAT_W];
          learn_d = bus.in_learn;
          label_d = bus.in_label;
          cls_d   = '0;
          j_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = total;
        if (j_q == JW'(N_FEAT-1)) begin
          j_d = '0;
          // Strict compare keeps the lowest class index on a tie.
          if (cls_q == '0 || total > max_q) begin
            max_d = total;
            idx_d = cls_q;
          end
          if (cls_q == CW'(N_CLASS-1)) state_d = ST_CMP;
          else                         cls_d   = cls_q + CW'(1);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      ST_CMP: begin
        out_class_d = idx_q;
        out_score_d = max_q;
        j_d         = '0;
        if (do_update) begin
          state_d = ST_LEARN;
        end else begin
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_LEARN: begin
        w_d[label_q][j_q] = lbl_w_new;
        w_d[idx_q][j_q]   = prd_w_new;
        if (j_q == '0) begin
          w_d[label_q][N_FEAT] = WEIGHT_W'(sat_add(int'(w_q[label_q][N_FEAT]), 1, WEIGHT_W));
          w_d[idx_q][N_FEAT]   = WEIGHT_W'(sat_add(int'(w_q[idx_q][N_FEAT]), -1, WEIGHT_W));
        end
        if (j_q == JW'(N_FEAT-1)) begin
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cls_q       <= '0;
      idx_q       <= '0;
      label_q     <= '0;
      out_class_q <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      max_q       <= '0;
      out_score_q <= '0;
      learn_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      for (int j = 0; j < N_FEAT; j++) feat_q[j] <= '0;
      for (int c = 0; c < N_CLASS; c++)
        for (int j = 0; j <= N_FEAT; j++) w_q[c][j] <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      idx_q       <= idx_d;
      label_q     <= label_d;
      out_class_q <= out_class_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      out_score_q <= out_score_d;
      learn_q     <= learn_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      feat_q      <= feat_d;
      w_q         <= w_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_score = out_score_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_perceptron_mac.sv
// Bench for perceptron_mac (N_FEAT=2, FEAT_W=4, N_CLASS=3, WEIGHT_W=4) against
// an arithmetic reference model of scores, arg-max and perceptron updates.
module tb_perceptron_mac;
  localparam int NF = 2;
  localparam int FW = 4;
  localparam int NC = 3;
  localparam int WW = 4;
  localparam int AW = FW + WW + 1 + $clog2(NF + 1);

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   wm [NC][NF+1];

  perceptron_mac_if #(.N_FEAT(NF), .FEAT_W(FW), .N_CLASS(NC), .WEIGHT_W(WW), .ACC_W(AW)) bus ();

  perceptron_mac #(.N_FEAT(NF), .FEAT_W(FW), .N_CLASS(NC), .WEIGHT_W(WW), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampw(input int v);
    int hi;
    hi = (1 << (WW - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NC; c++)
      for (int j = 0; j <= NF; j++) wm[c][j] = 0;
  endfunction

  function automatic void model_predict(input int x0, input int x1, output int cls, output int score);
    int xv [NF];
    int s;
    xv[0] = x0;
    xv[1] = x1;
    cls   = 0;
    score = 0;
    for (int c = 0; c < NC; c++) begin
      s = wm[c][NF];
      for (int j = 0; j < NF; j++) s += wm[c][j] * xv[j];
      if (c == 0 || s > score) begin
        score = s;
        cls   = c;
      end
    end
  endfunction

  // Predict, then apply the perceptron rule when labelled and wrong.
  function automatic void model_step(input int x0, input int x1, input bit learn, input int label,
                                     output int cls, output int score, output int err, output int lat);
    int xv [NF];
    xv[0] = x0;
    xv[1] = x1;
    model_predict(x0, x1, cls, score);
    err = 0;
    lat = NC * NF + 1;
    if (learn && label < NC && label != cls) begin
      for (int j = 0; j < NF; j++) begin
        wm[label][j] = clampw(wm[label][j] + xv[j]);
        wm[cls][j]   = clampw(wm[cls][j] - xv[j]);
      end
      wm[label][NF] = clampw(wm[label][NF] + 1);
      wm[cls][NF]   = clampw(wm[cls][NF] - 1);
      err = 1;
      lat = NC * NF + 1 + NF;
    end
  endfunction

  task automatic write_w(input int c, input int s, input int d);
    bus.w_we    = 1'b1;
    bus.w_class = 2'(c);
    bus.w_sel   = 2'(s);
    bus.w_data  = WW'(d);
    wm[c][s]    = d;
    tick();
    bus.w_we = 1'b0;
  endtask

  task automatic run_sample(input int x0, input int x1, input bit learn, input int label,
                            input bit do_w, input int wc, input int ws, input int wd,
                            output int ocls, output int oscore);
    int ecls, escore, eerr, elat, lat;
    chk("in_ready_idle", bus.in_ready, 1);
    if (do_w) begin
      bus.w_we    = 1'b1;
      bus.w_class = 2'(wc);
      bus.w_sel   = 2'(ws);
      bus.w_data  = WW'(wd);
      wm[wc][ws]  = wd;
    end
    bus.in_valid = 1'b1;
    bus.in_feat  = {FW'(x1), FW'(x0)};
    bus.in_learn = learn;
    bus.in_label = 2'(label);
    model_step(x0, x1, learn, label, ecls, escore, eerr, elat);
    tick();
    bus.in_valid = 1'b0;
    bus.w_we     = 1'b0;
    chk("in_ready_busy", bus.in_ready, 0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", lat, elat);
    chk("out_class", bus.out_class, ecls);
    chk("out_score", bus.out_score, escore);
    chk("out_err", bus.out_err, eerr);
    ocls   = int'(bus.out_class);
    oscore = int'(bus.out_score);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_clear", bus.out_valid, 0);
  endtask

  initial begin
    int cls, score, ecls, escore, eerr, elat, lat;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_feat   = '0;
    bus.in_learn  = 1'b0;
    bus.in_label  = '0;
    bus.w_we      = 1'b0;
    bus.w_class   = '0;
    bus.w_sel     = '0;
    bus.w_data    = '0;
    bus.out_ready = 1'b0;
    model_clear();
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_class", bus.out_class, 0);
    chk("rst_out_score", bus.out_score, 0);
    chk("rst_out_err", bus.out_err, 0);

    // Zero weights: everything ties at 0, class 0 wins.
    run_sample(3, 5, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);
    chk("zero_class_lit", cls, 0);
    chk("zero_score_lit", score, 0);

    // Tie between classes 1 and 2 resolves to the lower index.
    write_w(1, 0, 1); write_w(1, 1, 1);
    write_w(2, 0, 1); write_w(2, 1, 1);
    run_sample(3, 5, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);
    chk("tie_class_lit", cls, 1);
    chk("tie_score_lit", score, 8);

    write_w(1, 0, 2); write_w(1, 1, 1);
    write_w(2, 0, 1); write_w(2, 1, 2);
    run_sample(3, 5, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);
    chk("infer_class_lit", cls, 2);
    chk("infer_score_lit", score, 13);

    // Misprediction with label 1 trains w1 up and w2 down.
    run_sample(3, 5, 1'b1, 1, 1'b0, 0, 0, 0, cls, score);
    chk("learn_class_lit", cls, 2);
    run_sample(3, 5, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);
    chk("relearn_class_lit", cls, 1);
    chk("relearn_score_lit", score, 46);

    // Label 3 is out of range: no update even though learn is set.
    run_sample(2, 7, 1'b1, 3, 1'b0, 0, 0, 0, cls, score);
    run_sample(2, 7, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);

    // Saturation at both ends of the weight range.
    rst = 1'b1; tick(); rst = 1'b0; model_clear();
    write_w(0, 0, 7);
    write_w(1, 0, 7);
    run_sample(15, 0, 1'b1, 1, 1'b0, 0, 0, 0, cls, score);
    chk("sat_pred_lit", cls, 0);
    chk("sat_w1_model", wm[1][0], 7);
    run_sample(15, 0, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);
    chk("sat_readback_score_lit", score, 106);
    run_sample(1, 0, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);

    // Weight write on the accept edge is used by that sample.
    run_sample(4, 4, 1'b0, 0, 1'b1, 2, 2, 7, cls, score);

    for (int i = 0; i < 30; i++) begin
      run_sample($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, NC - 1),
                 $urandom_range(0, NF), $urandom_range(0, 15) - 8, cls, score);
    end

    // Backpressure: result held, no accept and no weight write while in OUT.
    model_predict(7, 9, ecls, escore);
    bus.in_valid = 1'b1;
    bus.in_feat  = {FW'(9), FW'(7)};
    bus.in_learn = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("bp_latency", lat, NC * NF + 1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_feat  = {FW'(1), FW'(1)};
      bus.w_we     = 1'b1;
      bus.w_class  = 2'(ecls);
      bus.w_sel    = 2'(0);
      bus.w_data   = WW'(-5);
      tick();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_class", bus.out_class, ecls);
      chk("bp_out_score", bus.out_score, escore);
    end
    bus.in_valid  = 1'b0;
    bus.w_we      = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_done_valid", bus.out_valid, 0);
    chk("bp_done_ready", bus.in_ready, 1);
    tick();
    chk("bp_no_accept", bus.in_ready, 1);
    run_sample(7, 9, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);

    // Reset in the middle of MAC aborts and clears the weights.
    write_w(2, 2, 5);
    bus.in_valid = 1'b1;
    bus.in_feat  = {FW'(5), FW'(3)};
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    model_clear();
    run_sample(3, 5, 1'b0, 0, 1'b0, 0, 0, 0, cls, score);
    chk("midrst_score_lit", score, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
